// File: rtl/add_prof_pkg.sv
// Shared widths and FSM state encoding for the approximate-adder error profiler.
package add_prof_pkg;

  // Operand width of the adders in the library.
  localparam int ADD_W = 8;

  // Derived widths, sized so that no accumulator can overflow over a full sweep.
  function automatic int sw_of(input int w);  // sum / |error|
    return w + 1;
  endfunction

  function automatic int cw_of(input int w);  // error count, up to 2^(2w)
    return 2 * w + 1;
  endfunction

  function automatic int aw_of(input int w);  // sum of |error|
    return 3 * w + 1;
  endfunction

  function automatic int qw_of(input int w);  // sum of error squared
    return 4 * w + 2;
  endfunction

  localparam int SW = sw_of(ADD_W);
  localparam int CW = cw_of(ADD_W);
  localparam int AW = aw_of(ADD_W);
  localparam int QW = qw_of(ADD_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/add_err_calc.sv
// Combinational error arithmetic: exact sum of the presented pair, plus
// |approx - exact| and its square for the pair held in the stage-1 registers.
module add_err_calc #(
  parameter int W = add_prof_pkg::ADD_W
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W:0]     approx_q,
  input  logic [W:0]     exact_q,
  output logic [W:0]     exact,
  output logic [W:0]     err_abs,
  output logic [2*W+1:0] err_sq
);

  logic signed [W+1:0] diff;
  logic signed [W+1:0] diff_neg;

  // One extra bit on both operands keeps the sum exact.
  assign exact    = {1'b0, a} + {1'b0, b};

  // Zero-extend before subtracting so the sign bit is meaningful.
  assign diff     = $signed({1'b0, approx_q}) - $signed({1'b0, exact_q});
  assign diff_neg = -diff;
  // |diff| never exceeds 2^(W+1)-1, so dropping the sign bit is lossless.
  assign err_abs  = diff[W+1] ? diff_neg[W:0] : diff[W:0];

  assign err_sq   = {{(W+1){1'b0}}, err_abs} * {{(W+1){1'b0}}, err_abs};

endmodule

// File: rtl/add8u_err_profiler.sv
// Exhaustive error profiler for an unsigned approximate adder: sweeps every
// operand pair, compares the adder output to the exact sum and accumulates
// error count, sum |e|, sum e^2, worst-case |e| and the first pair reaching it.
module add8u_err_profiler
  import add_prof_pkg::*;
#(
  parameter int W = ADD_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [W-1:0]           op_a,
  output logic [W-1:0]           op_b,
  input  logic [sw_of(W)-1:0]    approx_sum,
  output logic                   busy,
  output logic                   done,
  output logic [cw_of(W)-1:0]    err_cnt,
  output logic [aw_of(W)-1:0]    sum_abs_err,
  output logic [qw_of(W)-1:0]    sum_sq_err,
  output logic [sw_of(W)-1:0]    max_abs_err,
  output logic [W-1:0]           wc_a,
  output logic [W-1:0]           wc_b
);

  localparam int SUM_W = sw_of(W);
  localparam int CNT_W = cw_of(W);
  localparam int ABS_W = aw_of(W);
  localparam int SQ_W  = qw_of(W);

  state_t             state;
  logic               start_ok;
  logic               last_pair;
  logic [2*W-1:0]     pair_next;

  logic               s1_valid;
  logic [W-1:0]       s1_a;
  logic [W-1:0]       s1_b;
  logic [SUM_W-1:0]   s1_approx;
  logic [SUM_W-1:0]   s1_exact;

  logic [SUM_W-1:0]   exact;
  logic [SUM_W-1:0]   err_abs;
  logic [2*W+1:0]     err_sq;

  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign last_pair = (op_a == {W{1'b1}}) && (op_b == {W{1'b1}});
  assign pair_next = {op_a, op_b} + (2*W)'(1);

  assign busy = (state == SWEEP) || (state == DRAIN);
  assign done = (state == DONE);

  add_err_calc #(.W(W)) u_calc (
    .a        (op_a),
    .b        (op_b),
    .approx_q (s1_approx),
    .exact_q  (s1_exact),
    .exact    (exact),
    .err_abs  (err_abs),
    .err_sq   (err_sq)
  );

  // FSM and pair counter; op_b is the low half so it increments fastest.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, so it lives inside the edge branch rather than the sensitivity list.
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      // NOTE: non-blocking updates make every register see pre-edge values, which is what the pipeline relies on.
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state <= SWEEP;
            op_a  <= '0;
            op_b  <= '0;
          end
        end
        SWEEP: begin
          {op_a, op_b} <= pair_next;  // wraps to 0 after the last pair
          if (last_pair) state <= DRAIN;
        end
        DRAIN:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: capture the adder result, the exact sum and the pair that produced them.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_approx <= '0;
      s1_exact  <= '0;
    end else begin
      s1_valid <= (state == SWEEP);
      if (state == SWEEP) begin
        s1_a      <= op_a;
        s1_b      <= op_b;
        s1_approx <= approx_sum;
        s1_exact  <= exact;
      end
    end
  end

  // Stage 2: accumulate statistics; worst case uses a strict compare so the first pair wins.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      err_cnt     <= '0;
      sum_abs_err <= '0;
      sum_sq_err  <= '0;
      max_abs_err <= '0;
      wc_a        <= '0;
      wc_b        <= '0;
    end else if (s1_valid) begin
      if (err_abs != '0) begin
        err_cnt     <= err_cnt + CNT_W'(1);
        sum_abs_err <= sum_abs_err + ABS_W'(err_abs);
        sum_sq_err  <= sum_sq_err + SQ_W'(err_sq);
      end
      if (err_abs > max_abs_err) begin
        max_abs_err <= err_abs;
        wc_a        <= s1_a;
        wc_b        <= s1_b;
      end
    end
  end

endmodule

// File: tb/tb_add8u_err_profiler.sv
// Directed bench for add8u_err_profiler, built at W=4 (256 pairs per sweep) so
// every scenario runs a complete exhaustive sweep. Expected statistics are
// hand-derived for each synthetic adder model below.
module tb_add8u_err_profiler;

  localparam int W      = 4;
  localparam int SW     = W + 1;
  localparam int CW     = 2 * W + 1;
  localparam int AW     = 3 * W + 1;
  localparam int QW     = 4 * W + 2;
  localparam int EDGES  = (1 << (2 * W)) + 1;  // start edge to done
  localparam int LIMIT  = 2000;

  // Adder models driven onto approx_sum.
  localparam int M_EXACT = 0;
  localparam int M_ZERO  = 1;
  localparam int M_PLUS1 = 2;
  localparam int M_LSB0  = 3;
  localparam int M_ONES  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  op_a, op_b;
  logic [SW-1:0] approx_sum;
  logic          busy, done;
  logic [CW-1:0] err_cnt;
  logic [AW-1:0] sum_abs_err;
  logic [QW-1:0] sum_sq_err;
  logic [SW-1:0] max_abs_err;
  logic [W-1:0]  wc_a, wc_b;

  int            mode = M_EXACT;
  logic [SW-1:0] exact_tb;
  int            cyc = 0;
  int            checks = 0;
  int            passes = 0;

  add8u_err_profiler #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .approx_sum  (approx_sum),
    .busy        (busy),
    .done        (done),
    .err_cnt     (err_cnt),
    .sum_abs_err (sum_abs_err),
    .sum_sq_err  (sum_sq_err),
    .max_abs_err (max_abs_err),
    .wc_a        (wc_a),
    .wc_b        (wc_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign exact_tb = {1'b0, op_a} + {1'b0, op_b};

  always_comb begin
    approx_sum = exact_tb;
    case (mode)
      M_ZERO:  approx_sum = '0;
      M_PLUS1: approx_sum = exact_tb + SW'(1);
      M_LSB0:  approx_sum = {exact_tb[SW-1:1], 1'b0};
      M_ONES:  approx_sum = '1;
      default: approx_sum = exact_tb;
    endcase
  end

  task automatic pulse_start(output int k);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b0;
  endtask

  task automatic wait_pair(input int p);
    int guard = 0;
    while ({op_a, op_b} != (2*W)'(p) && guard < LIMIT) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({op_a, op_b, busy, done, err_cnt, sum_abs_err, sum_sq_err, max_abs_err, wc_a, wc_b} !== '0)
      $display("FAIL reset_outputs: got busy=%0b done=%0b ops=%0d/%0d cnt=%0d expected all zero",
               busy, done, op_a, op_b, err_cnt);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL idle_after_reset: got busy=%0b done=%0b expected 0/0", busy, done);
    else passes++;
  endtask

  // Full sweep under one adder model, checking timing and every statistic.
  task automatic test_sweep(input int m, input string name, input int e_cnt, input int e_abs,
                            input int e_sq, input int e_max, input int e_wa, input int e_wb);
    int k;
    bit gap = 1'b0;
    mode = m;
    pulse_start(k);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL %s start_flags: got busy=%0b done=%0b expected 1/0", name, busy, done);
    else passes++;
    while (done !== 1'b1 && cyc - k < LIMIT) begin
      if (busy !== 1'b1) gap = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (cyc - k != EDGES || gap)
      $display("FAIL %s latency: got %0d edges (busy gap %0b) expected %0d", name, cyc - k, gap, EDGES);
    else passes++;
    checks++;
    if (busy !== 1'b0 || op_a !== '0 || op_b !== '0)
      $display("FAIL %s done_state: got busy=%0b ops=%0d/%0d expected 0 0/0", name, busy, op_a, op_b);
    else passes++;
    checks++;
    if (err_cnt !== CW'(e_cnt))
      $display("FAIL %s err_cnt: got %0d expected %0d", name, err_cnt, e_cnt);
    else passes++;
    checks++;
    if (sum_abs_err !== AW'(e_abs))
      $display("FAIL %s sum_abs_err: got %0d expected %0d", name, sum_abs_err, e_abs);
    else passes++;
    checks++;
    if (sum_sq_err !== QW'(e_sq))
      $display("FAIL %s sum_sq_err: got %0d expected %0d", name, sum_sq_err, e_sq);
    else passes++;
    checks++;
    if (max_abs_err !== SW'(e_max) || wc_a !== W'(e_wa) || wc_b !== W'(e_wb))
      $display("FAIL %s worst_case: got max=%0d at (%0d,%0d) expected %0d at (%0d,%0d)",
               name, max_abs_err, wc_a, wc_b, e_max, e_wa, e_wb);
    else passes++;
    // Statistics must hold while idling in DONE.
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || err_cnt !== CW'(e_cnt) || max_abs_err !== SW'(e_max))
      $display("FAIL %s hold: got done=%0b cnt=%0d max=%0d expected 1 %0d %0d",
               name, done, err_cnt, max_abs_err, e_cnt, e_max);
    else passes++;
  endtask

  // Zero adder: a start mid-sweep is ignored, then rst aborts a second sweep.
  task automatic test_ignore_and_abort();
    int k, k2;
    mode = M_ZERO;
    pulse_start(k);
    wait_pair(100);
    pulse_start(k2);
    while (done !== 1'b1 && cyc - k < LIMIT) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (cyc - k != EDGES)
      $display("FAIL ignored_start latency: got %0d edges expected %0d", cyc - k, EDGES);
    else passes++;
    checks++;
    if (err_cnt !== CW'(255) || sum_abs_err !== AW'(3840) || max_abs_err !== SW'(30))
      $display("FAIL ignored_start totals: got cnt=%0d abs=%0d max=%0d expected 255 3840 30",
               err_cnt, sum_abs_err, max_abs_err);
    else passes++;
    pulse_start(k);
    wait_pair(200);
    checks++;
    if (err_cnt === '0)
      $display("FAIL abort_partial: got cnt=%0d expected nonzero before reset", err_cnt);
    else passes++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({op_a, op_b, busy, done, err_cnt, sum_abs_err, sum_sq_err, max_abs_err, wc_a, wc_b} !== '0)
      $display("FAIL abort_reset: got busy=%0b done=%0b ops=%0d/%0d cnt=%0d abs=%0d expected all zero",
               busy, done, op_a, op_b, err_cnt, sum_abs_err);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || err_cnt !== '0)
      $display("FAIL abort_stays_idle: got busy=%0b cnt=%0d expected 0 0", busy, err_cnt);
    else passes++;
    test_sweep(M_ZERO, "after_abort", 255, 3840, 68480, 30, 15, 15);
  endtask

  // Restart from DONE: done drops at once, statistics clear, result repeats.
  task automatic test_back_to_back();
    int k;
    test_sweep(M_PLUS1, "b2b_first", 256, 256, 256, 1, 0, 0);
    pulse_start(k);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_restart_flags: got done=%0b busy=%0b expected 0/1", done, busy);
    else passes++;
    checks++;
    if ({err_cnt, sum_abs_err, sum_sq_err, max_abs_err, wc_a, wc_b} !== '0)
      $display("FAIL b2b_cleared: got cnt=%0d abs=%0d max=%0d expected 0", err_cnt, sum_abs_err, max_abs_err);
    else passes++;
    while (done !== 1'b1 && cyc - k < LIMIT) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (cyc - k != EDGES)
      $display("FAIL b2b_latency: got %0d edges expected %0d", cyc - k, EDGES);
    else passes++;
    checks++;
    if (err_cnt !== CW'(256) || sum_abs_err !== AW'(256) || sum_sq_err !== QW'(256) ||
        max_abs_err !== SW'(1) || wc_a !== '0 || wc_b !== '0)
      $display("FAIL b2b_second: got cnt=%0d abs=%0d sq=%0d max=%0d wc=(%0d,%0d) expected 256 256 256 1 (0,0)",
               err_cnt, sum_abs_err, sum_sq_err, max_abs_err, wc_a, wc_b);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_sweep(M_EXACT, "exact", 0, 0, 0, 0, 0, 0);
    test_sweep(M_ZERO,  "zero", 255, 3840, 68480, 30, 15, 15);
    test_sweep(M_PLUS1, "plus1", 256, 256, 256, 1, 0, 0);
    test_sweep(M_LSB0,  "lsb0", 128, 128, 128, 1, 0, 1);
    test_sweep(M_ONES,  "ones", 256, 4096, 76416, 31, 0, 0);
    test_ignore_and_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
